// File: rtl/alu_div_sequencer_pkg.sv
// Shared types for the iterative divide/remainder unit in the execute stage.
//   Data     : operand/result word
//   DivOp    : RV32M divide-family operation selector
//   DivState : sequencer state
package alu_div_sequencer_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] Data;

  typedef enum logic [1:0] {
    DivOp_DIV,
    DivOp_DIVU,
    DivOp_REM,
    DivOp_REMU
  } DivOp;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } DivState;

  function automatic logic isSignedOp(input DivOp op);
    return (op == DivOp_DIV) || (op == DivOp_REM);
  endfunction

  function automatic logic isRemOp(input DivOp op);
    return (op == DivOp_REM) || (op == DivOp_REMU);
  endfunction

endpackage

// File: rtl/alu_div_sequencer_adder.sv
// Plain ripple-style adder used for the trial subtraction of the divider.
//   a, b    : addends (WIDTH bits)
//   carryIn : carry into bit 0 (1 with inverted b gives a - b)
//   sum     : a + b + carryIn, truncated to WIDTH bits
module alu_div_sequencer_adder #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b + WIDTH'(carryIn);

endmodule

// File: rtl/alu_div_sequencer.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle over WIDTH cycles; divide-by-zero and signed
// overflow skip the iteration and report after one cycle.
//   i_clock/i_reset : clock, asynchronous active-low reset
//   i_flush         : synchronous abort, discards any in-flight or pending result
//   i_op, i_dataA, i_dataB, i_valid, o_ready : request handshake
//   o_result, o_valid, i_ready               : result handshake
//   o_busy          : high while an operation is in CALC or DONE (pipeline stall)
module alu_div_sequencer
  import alu_div_sequencer_pkg::*;
#(
  parameter int WIDTH = $bits(Data),
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  DivOp             i_op,
  input  logic [WIDTH-1:0] i_dataA,
  input  logic [WIDTH-1:0] i_dataB,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy
);

  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  DivState          state, nextState;
  DivOp             opReg;
  logic [WIDTH-1:0] quot, rem, divisor;
  logic             negQ, negR;
  logic [CNT_W-1:0] counter;

  // Request decode
  logic             accept, reqSigned, divByZero, overflow, special;
  logic [WIDTH-1:0] magA, magB;

  assign accept    = (state == IDLE) && i_valid && !i_flush;
  assign reqSigned = isSignedOp(i_op);
  assign divByZero = (i_dataB == '0);
  assign overflow  = reqSigned && (i_dataA == MIN_NEG) && (i_dataB == ALL_ONES);
  assign special   = divByZero || overflow;
  // -0x80000000 wraps to itself, which is the correct magnitude read unsigned.
  assign magA      = (reqSigned && i_dataA[WIDTH-1]) ? -i_dataA : i_dataA;
  assign magB      = (reqSigned && i_dataB[WIDTH-1]) ? -i_dataB : i_dataB;

  // Trial subtraction: {0, rem[W-2:0], quot[W-1]} - {0, divisor}.
  // When rem[W-1] is set the true shifted remainder is >= 2^W, so it can never
  // borrow, and the low WIDTH bits of the difference are still exact.
  logic [WIDTH:0] trialDiff;
  logic           noBorrow;

  alu_div_sequencer_adder #(.WIDTH(WIDTH + 1)) u_trialSub (
    .a       ({1'b0, rem[WIDTH-2:0], quot[WIDTH-1]}),
    .b       (~{1'b0, divisor}),
    .carryIn (1'b1),
    .sum     (trialDiff)
  );

  assign noBorrow = rem[WIDTH-1] || !trialDiff[WIDTH];

  logic [WIDTH-1:0] finalResult;
  assign finalResult = isRemOp(opReg) ? (negR ? -rem : rem)
                                      : (negQ ? -quot : quot);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (accept) nextState = special ? DONE : CALC;
      CALC:    if (counter == LAST_STEP) nextState = DONE;
      DONE:    if (o_valid && i_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (i_flush) nextState = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      opReg    <= DivOp_DIVU;
      quot     <= '0;
      rem      <= '0;
      divisor  <= '0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      counter  <= '0;
      o_result <= '0;
      o_valid  <= 1'b0;
    end else begin
      state <= nextState;

      // Result is registered on the first DONE cycle; o_valid follows it and
      // drops on the handshake edge.
      o_valid <= (state == DONE) && !i_flush && !(o_valid && i_ready);
      if ((state == DONE) && !o_valid && !i_flush) o_result <= finalResult;

      unique case (state)
        IDLE: begin
          if (accept) begin
            opReg   <= i_op;
            divisor <= magB;
            counter <= '0;
            if (special) begin
              // Preload quot/rem with the architectural answer, unsigned, so
              // the common result path in DONE produces it unchanged.
              quot <= divByZero ? ALL_ONES : MIN_NEG;
              rem  <= divByZero ? i_dataA : '0;
              negQ <= 1'b0;
              negR <= 1'b0;
            end else begin
              quot <= magA;
              rem  <= '0;
              negQ <= reqSigned && (i_dataA[WIDTH-1] ^ i_dataB[WIDTH-1]);
              negR <= reqSigned && i_dataA[WIDTH-1];
            end
          end
        end
        CALC: begin
          if (noBorrow) begin
            rem  <= trialDiff[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= {rem[WIDTH-2:0], quot[WIDTH-1]};
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
          counter <= counter + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed self-checking bench for alu_div_sequencer.
module tb_alu_div_sequencer;
  import alu_div_sequencer_pkg::*;

  logic        i_clock;
  logic        i_reset;
  logic        i_flush;
  DivOp        i_op;
  logic [31:0] i_dataA;
  logic [31:0] i_dataB;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_result;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  alu_div_sequencer dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_flush  (i_flush),
    .i_op     (i_op),
    .i_dataA  (i_dataA),
    .i_dataB  (i_dataB),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_result (o_result),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_busy   (o_busy)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Present one request, measure edges from accept to o_valid, check the
  // result, then (with i_ready=1) check the handshake returns to IDLE.
  task automatic runOp(input string tag, input DivOp op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes,
                       input int expLat);
    int lat;
    check({tag, " ready before"}, {31'b0, o_ready}, 32'd1);
    i_op    = op;
    i_dataA = a;
    i_dataB = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(expLat));
    check({tag, " result"}, o_result, expRes);
    tick();
    check({tag, " ready after handshake"}, {31'b0, o_ready}, 32'd1);
    check({tag, " valid after handshake"}, {31'b0, o_valid}, 32'd0);
  endtask

  task automatic startOp(input DivOp op, input logic [31:0] a, input logic [31:0] b);
    i_op    = op;
    i_dataA = a;
    i_dataB = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    int highs;
    i_reset = 1'b0;
    i_flush = 1'b0;
    i_op    = DivOp_DIVU;
    i_dataA = '0;
    i_dataB = '0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) tick();

    // Reset values
    check("reset o_ready", {31'b0, o_ready}, 32'd1);
    check("reset o_valid", {31'b0, o_valid}, 32'd0);
    check("reset o_busy", {31'b0, o_busy}, 32'd0);
    check("reset o_result", o_result, 32'd0);
    i_reset = 1'b1;
    tick();

    // Normal unsigned and signed operations: 33 edges from accept to o_valid
    runOp("DIVU 100/7", DivOp_DIVU, 32'd100, 32'd7, 32'd14, 33);
    runOp("REMU 100/7", DivOp_REMU, 32'd100, 32'd7, 32'd2, 33);
    runOp("DIV -7/2", DivOp_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    runOp("REM -7/2", DivOp_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    runOp("REM 7/-2", DivOp_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    runOp("DIVU big", DivOp_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
    runOp("REMU big", DivOp_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);

    // Special cases: one edge from accept to o_valid
    runOp("DIVU by zero", DivOp_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("REM by zero", DivOp_REM, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
    runOp("DIV overflow", DivOp_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("REM overflow", DivOp_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    runOp("DIV zero over ovf", DivOp_DIV, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1);

    // Result held while the consumer stalls
    i_ready = 1'b0;
    startOp(DivOp_DIVU, 32'hFFFF_FFFF, 32'd1);
    highs = 0;
    while (!o_valid && highs < 200) begin
      tick();
      highs++;
    end
    check("hold latency", 32'(highs), 32'd33);
    for (int i = 0; i < 10; i++) begin
      check("hold o_result", o_result, 32'hFFFF_FFFF);
      check("hold o_ready", {31'b0, o_ready}, 32'd0);
      check("hold o_valid", {31'b0, o_valid}, 32'd1);
      tick();
    end
    i_ready = 1'b1;
    tick();
    check("hold release o_ready", {31'b0, o_ready}, 32'd1);
    check("hold release o_valid", {31'b0, o_valid}, 32'd0);

    // Flush mid-CALC discards the operation
    startOp(DivOp_DIVU, 32'd1000, 32'd3);
    repeat (10) tick();
    check("flush busy before", {31'b0, o_busy}, 32'd1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("flush o_ready", {31'b0, o_ready}, 32'd1);
    check("flush o_busy", {31'b0, o_busy}, 32'd0);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_valid) highs++;
      tick();
    end
    check("flush no o_valid", 32'(highs), 32'd0);
    runOp("DIVU 9/3 after flush", DivOp_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Flush in IDLE wins over i_valid: no accept
    i_flush = 1'b1;
    startOp(DivOp_DIVU, 32'd5, 32'd1);
    i_flush = 1'b0;
    check("flush-in-idle no accept", {31'b0, o_busy}, 32'd0);

    // Asynchronous reset mid-CALC
    startOp(DivOp_DIVU, 32'd1000, 32'd3);
    repeat (10) tick();
    i_reset = 1'b0;
    #1;
    check("async reset o_ready", {31'b0, o_ready}, 32'd1);
    check("async reset o_busy", {31'b0, o_busy}, 32'd0);
    check("async reset o_valid", {31'b0, o_valid}, 32'd0);
    check("async reset o_result", o_result, 32'd0);
    tick();
    i_reset = 1'b1;
    tick();
    runOp("DIVU 1000/3 after reset", DivOp_DIVU, 32'd1000, 32'd3, 32'd333, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
